// File: rtl/riscv_param_scoreboard.sv
// Parameterised N-wide register scoreboard for the out-of-order-issue core.
// Tracks every architectural register that has an in-flight writer: which
// pipe it is in, where in that pipe the result sits (one-hot latency vector),
// what class of result it is and the ROB tag of the writer.
//
// Handshake: there is no valid/ready pair on this block. An issue slot is
// consumed when iss_val[k] is high at posedge clk. The issue stage must not
// raise iss_val[k] while stall[k] is high. stall[k] is purely combinational
// from registered state and the current slot inputs.
module riscv_param_scoreboard #(
  parameter int NREG      = 32,
  parameter int ISSUE_W   = 2,
  parameter int NPIPE     = 2,
  parameter int DEPTH     = 5,
  parameter int SHORT_POS = 1,
  parameter logic [NPIPE-1:0] LONG_MASK = NPIPE'('b01),
  parameter int MUL_READY = 1,
  parameter int TAG_W     = 5,
  parameter int NCOMMIT   = 2,
  localparam int RW = $clog2(NREG),
  localparam int PW = (NPIPE > 1) ? $clog2(NPIPE) : 1,
  localparam int SW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ISSUE_W-1:0]         iss_val,
  input  logic [ISSUE_W*RW-1:0]      iss_dst,
  input  logic [ISSUE_W*RW-1:0]      iss_src0,
  input  logic [ISSUE_W*RW-1:0]      iss_src1,
  input  logic [ISSUE_W-1:0]         iss_dst_en,
  input  logic [ISSUE_W-1:0]         iss_src0_en,
  input  logic [ISSUE_W-1:0]         iss_src1_en,
  input  logic [ISSUE_W*PW-1:0]      iss_pipe,
  input  logic [ISSUE_W*2-1:0]       iss_func,
  input  logic [ISSUE_W*TAG_W-1:0]   iss_tag,
  input  logic                       inst_val,
  input  logic [NPIPE*DEPTH-1:0]     stall_stage,
  input  logic [NCOMMIT-1:0]         commit_val,
  input  logic [NCOMMIT*TAG_W-1:0]   commit_tag,
  input  logic                       flush,
  output logic [ISSUE_W*4-1:0]       byp_sel,
  output logic [ISSUE_W*2*PW-1:0]    byp_pipe,
  output logic [ISSUE_W*2*SW-1:0]    byp_stage,
  output logic [ISSUE_W*2*TAG_W-1:0] byp_tag,
  output logic [ISSUE_W-1:0]         stall
);

  typedef logic [DEPTH-1:0] lat_t;

  localparam lat_t       LAT_LONG  = lat_t'(1) << (DEPTH - 1);
  localparam lat_t       LAT_SHORT = lat_t'(1) << SHORT_POS;
  localparam logic [1:0] FUNC_MEM  = 2'b01;
  localparam logic [1:0] FUNC_MUL  = 2'b10;

  logic             pend_q [NREG];
  logic [PW-1:0]    pipe_q [NREG];
  lat_t             lat_q  [NREG];
  logic [1:0]       func_q [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];

  logic             pend_d [NREG];
  logic [PW-1:0]    pipe_d [NREG];
  lat_t             lat_d  [NREG];
  logic [1:0]       func_d [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];

  // Bit position of the (single) set bit of a latency vector; 0 when empty.
  function automatic int lat_pos(input lat_t lat);
    int pos;
    pos = 0;
    for (int b = 0; b < DEPTH; b++) begin
      if (lat[b]) pos = b;
    end
    return pos;
  endfunction

  // True when the stage currently holding this entry is stalled.
  function automatic logic stage_held(input logic [PW-1:0] p, input lat_t lat,
                                      input logic [NPIPE*DEPTH-1:0] stl);
    logic held;
    held = 1'b0;
    for (int q = 0; q < NPIPE; q++) begin
      for (int b = 0; b < DEPTH; b++) begin
        if (p == PW'(q) && lat[b]) held = stl[q*DEPTH + b];
      end
    end
    return held;
  endfunction

  // Long pipes insert at the X0 end of the latency vector.
  function automatic logic pipe_is_long(input logic [PW-1:0] p);
    logic lng;
    lng = 1'b0;
    for (int q = 0; q < NPIPE; q++) begin
      if (p == PW'(q)) lng = LONG_MASK[q];
    end
    return lng;
  endfunction

  // Whether a consumer may take this producer's result right now.
  function automatic logic op_ready(input logic [1:0] f, input lat_t lat);
    logic rdy;
    case (f)
      FUNC_MEM: rdy = int'(lat) < (1 << (DEPTH - 1));
      FUNC_MUL: rdy = int'(lat) < (1 << (MUL_READY + 1));
      default:  rdy = 1'b1;
    endcase
    return rdy;
  endfunction

  // Next-state: shift, then commit clear, then issue, with flush overriding all.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      pipe_d[r] = pipe_q[r];
      lat_d[r]  = lat_q[r];
      func_d[r] = func_q[r];
      tag_d[r]  = tag_q[r];
      if (lat_q[r] != '0 && !stage_held(pipe_q[r], lat_q[r], stall_stage)) begin
        lat_d[r] = lat_q[r] >> 1;
      end
      for (int c = 0; c < NCOMMIT; c++) begin
        if (pend_q[r] && commit_val[c] && commit_tag[c*TAG_W +: TAG_W] == tag_q[r]) begin
          pend_d[r] = 1'b0;
          lat_d[r]  = '0;
        end
      end
    end
    // Ascending slot order so the youngest writer of a register wins.
    for (int k = 0; k < ISSUE_W; k++) begin
      if (iss_val[k] && iss_dst_en[k] && iss_dst[k*RW +: RW] != '0) begin
        pend_d[iss_dst[k*RW +: RW]] = 1'b1;
        pipe_d[iss_dst[k*RW +: RW]] = iss_pipe[k*PW +: PW];
        func_d[iss_dst[k*RW +: RW]] = iss_func[k*2 +: 2];
        tag_d[iss_dst[k*RW +: RW]]  = iss_tag[k*TAG_W +: TAG_W];
        lat_d[iss_dst[k*RW +: RW]]  = pipe_is_long(iss_pipe[k*PW +: PW]) ? LAT_LONG : LAT_SHORT;
      end
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        pend_d[r] = 1'b0;
        lat_d[r]  = '0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) begin
        pend_q[r] <= 1'b0;
        pipe_q[r] <= '0;
        lat_q[r]  <= '0;
        func_q[r] <= '0;
        tag_q[r]  <= '0;
      end else begin
        pend_q[r] <= pend_d[r];
        pipe_q[r] <= pipe_d[r];
        lat_q[r]  <= lat_d[r];
        func_q[r] <= func_d[r];
        tag_q[r]  <= tag_d[r];
      end
    end
  end

  // Per-operand bypass selection and per-slot in-order stall chain.
  always_comb begin
    logic [RW-1:0] src;
    logic          en;
    logic          live;
    logic          hold;
    logic          prev;
    int            o;
    byp_sel   = '0;
    byp_pipe  = '0;
    byp_stage = '0;
    byp_tag   = '0;
    stall     = '0;
    src  = '0;
    en   = 1'b0;
    live = 1'b0;
    hold = 1'b0;
    prev = 1'b0;
    o    = 0;
    for (int k = 0; k < ISSUE_W; k++) begin
      hold = 1'b0;
      for (int j = 0; j < 2; j++) begin
        src  = (j == 0) ? iss_src0[k*RW +: RW] : iss_src1[k*RW +: RW];
        en   = (j == 0) ? iss_src0_en[k] : iss_src1_en[k];
        live = en && (src != '0) && pend_q[src];
        o    = 2*k + j;
        byp_tag[o*TAG_W +: TAG_W] = tag_q[src];
        if (live) begin
          if (lat_q[src] != '0) begin
            byp_sel[o*2 +: 2]    = 2'd1;
            byp_pipe[o*PW +: PW] = pipe_q[src];
            byp_stage[o*SW +: SW] = SW'(DEPTH - 1 - lat_pos(lat_q[src]));
          end else begin
            byp_sel[o*2 +: 2] = 2'd2;
          end
          if (!op_ready(func_q[src], lat_q[src])) hold = 1'b1;
        end
        // Older slot in this bundle writes a register this slot reads.
        for (int i = 0; i < k; i++) begin
          if (en && src != '0 && iss_val[i] && iss_dst_en[i] && iss_dst[i*RW +: RW] == src) begin
            hold = 1'b1;
          end
        end
      end
      prev     = inst_val && (hold || prev);
      stall[k] = prev;
    end
  end

endmodule

// File: tb/tb_riscv_param_scoreboard.sv
// Directed bench for riscv_param_scoreboard with hand-computed expectations.
module tb_riscv_param_scoreboard;

  localparam int ISSUE_W = 2;
  localparam int NPIPE   = 2;
  localparam int DEPTH   = 5;
  localparam int TAG_W   = 5;
  localparam int NCOMMIT = 2;
  localparam int RW      = 5;
  localparam int PW      = 1;
  localparam int SW      = 3;

  logic                       clk;
  logic                       reset;
  logic [ISSUE_W-1:0]         iss_val;
  logic [ISSUE_W*RW-1:0]      iss_dst;
  logic [ISSUE_W*RW-1:0]      iss_src0;
  logic [ISSUE_W*RW-1:0]      iss_src1;
  logic [ISSUE_W-1:0]         iss_dst_en;
  logic [ISSUE_W-1:0]         iss_src0_en;
  logic [ISSUE_W-1:0]         iss_src1_en;
  logic [ISSUE_W*PW-1:0]      iss_pipe;
  logic [ISSUE_W*2-1:0]       iss_func;
  logic [ISSUE_W*TAG_W-1:0]   iss_tag;
  logic                       inst_val;
  logic [NPIPE*DEPTH-1:0]     stall_stage;
  logic [NCOMMIT-1:0]         commit_val;
  logic [NCOMMIT*TAG_W-1:0]   commit_tag;
  logic                       flush;
  logic [ISSUE_W*4-1:0]       byp_sel;
  logic [ISSUE_W*2*PW-1:0]    byp_pipe;
  logic [ISSUE_W*2*SW-1:0]    byp_stage;
  logic [ISSUE_W*2*TAG_W-1:0] byp_tag;
  logic [ISSUE_W-1:0]         stall;

  int n_checks = 0;
  int n_pass   = 0;
  logic [SW-1:0] exp_q[$];

  riscv_param_scoreboard dut (
    .clk(clk), .reset(reset),
    .iss_val(iss_val), .iss_dst(iss_dst), .iss_src0(iss_src0), .iss_src1(iss_src1),
    .iss_dst_en(iss_dst_en), .iss_src0_en(iss_src0_en), .iss_src1_en(iss_src1_en),
    .iss_pipe(iss_pipe), .iss_func(iss_func), .iss_tag(iss_tag),
    .inst_val(inst_val), .stall_stage(stall_stage),
    .commit_val(commit_val), .commit_tag(commit_tag), .flush(flush),
    .byp_sel(byp_sel), .byp_pipe(byp_pipe), .byp_stage(byp_stage),
    .byp_tag(byp_tag), .stall(stall)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // Comparison counter and reporter.
  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, exp);
  endtask

  function automatic int get_sel(input int k, input int j);
    return int'(byp_sel[(2*k+j)*2 +: 2]);
  endfunction
  function automatic int get_pipe(input int k, input int j);
    return int'(byp_pipe[(2*k+j)*PW +: PW]);
  endfunction
  function automatic int get_stage(input int k, input int j);
    return int'(byp_stage[(2*k+j)*SW +: SW]);
  endfunction
  function automatic int get_tag(input int k, input int j);
    return int'(byp_tag[(2*k+j)*TAG_W +: TAG_W]);
  endfunction

  // Driver tasks.
  task automatic clear_srcs();
    iss_src0 = '0; iss_src1 = '0; iss_src0_en = '0; iss_src1_en = '0;
  endtask

  task automatic clear_inputs();
    iss_val = '0; iss_dst = '0; iss_dst_en = '0; iss_pipe = '0; iss_func = '0;
    iss_tag = '0; inst_val = 1'b0; stall_stage = '0; commit_val = '0;
    commit_tag = '0; flush = 1'b0;
    clear_srcs();
  endtask

  task automatic drive_issue(input int k, input int dst, input int pipe,
                             input int func, input int tag);
    iss_val[k] = 1'b1;
    iss_dst_en[k] = 1'b1;
    iss_dst[k*RW +: RW] = RW'(dst);
    iss_pipe[k*PW +: PW] = PW'(pipe);
    iss_func[k*2 +: 2] = 2'(func);
    iss_tag[k*TAG_W +: TAG_W] = TAG_W'(tag);
  endtask

  task automatic drive_src(input int k, input int j, input int r);
    if (j == 0) begin
      iss_src0[k*RW +: RW] = RW'(r); iss_src0_en[k] = 1'b1;
    end else begin
      iss_src1[k*RW +: RW] = RW'(r); iss_src1_en[k] = 1'b1;
    end
  endtask

  task automatic drive_commit(input int c, input int tag);
    commit_val[c] = 1'b1;
    commit_tag[c*TAG_W +: TAG_W] = TAG_W'(tag);
  endtask

  // Advance one clock; single-cycle strobes drop after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    iss_val = '0; iss_dst_en = '0; commit_val = '0; flush = 1'b0;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [SW-1:0] e;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    inst_val = 1'b1;
    drive_src(0, 0, 5);
    settle();
    check("reset_sel", get_sel(0, 0), 0);
    check("reset_stall", int'(stall), 0);

    // Load state, then reset mid-operation.
    drive_issue(0, 5, 0, 0, 7);
    tick();
    check("loaded_sel", get_sel(0, 0), 1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst2_sel", get_sel(0, 0), 0);
    check("rst2_tag", get_tag(0, 0), 0);
    check("rst2_stage", get_stage(0, 0), 0);
    check("rst2_stall", int'(stall), 0);

    // Long ALU walk through all stages then into the ROB.
    drive_issue(0, 5, 0, 0, 7);
    settle();
    check("walk_issue_cycle_sel", get_sel(0, 0), 0);
    tick();
    for (int s = 0; s < DEPTH; s++) exp_q.push_back(SW'(s));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("walk_sel", get_sel(0, 0), 1);
      check("walk_stage", get_stage(0, 0), int'(e));
      check("walk_pipe", get_pipe(0, 0), 0);
      check("walk_tag", get_tag(0, 0), 7);
      check("walk_stall", int'(stall), 0);
      tick();
    end
    check("walk_rob_sel", get_sel(0, 0), 2);
    check("walk_rob_tag", get_tag(0, 0), 7);
    check("walk_rob_stage", get_stage(0, 0), 0);
    drive_commit(1, 7);
    settle();
    check("walk_commit_cycle_sel", get_sel(0, 0), 2);
    tick();
    check("walk_committed_sel", get_sel(0, 0), 0);

    // MULDIV on long pipe: stalls at X0..X2, slot 1 follows slot 0.
    clear_srcs();
    drive_src(0, 0, 3);
    drive_issue(0, 3, 0, 2, 3);
    tick();
    for (int s = 0; s < DEPTH; s++) begin
      check("mul_stage", get_stage(0, 0), s);
      check("mul_stall", int'(stall), (s < 3) ? 3 : 0);
      tick();
    end
    check("mul_rob_sel", get_sel(0, 0), 2);
    check("mul_rob_stall", int'(stall), 0);
    drive_commit(0, 3);
    tick();

    // MULDIV on short pipe enters at X3 and is ready at once.
    clear_srcs();
    drive_src(0, 0, 9);
    drive_issue(0, 9, 1, 2, 4);
    tick();
    check("short_sel", get_sel(0, 0), 1);
    check("short_pipe", get_pipe(0, 0), 1);
    check("short_stage", get_stage(0, 0), 3);
    check("short_stall", int'(stall), 0);
    tick();
    check("short_w_stage", get_stage(0, 0), 4);
    tick();
    check("short_rob_sel", get_sel(0, 0), 2);
    drive_commit(0, 4);
    tick();

    // MEM on long pipe, then hold at X1 via stall_stage.
    clear_srcs();
    drive_src(0, 1, 10);
    drive_issue(0, 10, 0, 1, 10);
    tick();
    check("mem_x0_stall", int'(stall), 3);
    tick();
    check("mem_x1_stall", int'(stall), 0);
    check("mem_x1_stage", get_stage(0, 1), 1);
    stall_stage[0*DEPTH + 3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_stage", get_stage(0, 1), 1);
    end
    stall_stage = '0;
    tick();
    check("release_stage", get_stage(0, 1), 2);
    drive_commit(1, 10);
    tick();
    check("mem_committed_sel", get_sel(0, 1), 0);

    // Stale commit must not clear a newer writer.
    clear_srcs();
    drive_src(1, 0, 4);
    drive_issue(0, 4, 0, 0, 2);
    tick();
    drive_issue(0, 4, 0, 0, 9);
    tick();
    drive_commit(0, 2);
    tick();
    check("stale_sel", get_sel(1, 0), 1);
    check("stale_tag", get_tag(1, 0), 9);
    check("stale_stage", get_stage(1, 0), 1);
    drive_commit(1, 9);
    tick();
    check("fresh_commit_sel", get_sel(1, 0), 0);

    // Intra-bundle hazard.
    clear_srcs();
    drive_issue(0, 6, 0, 0, 5);
    drive_src(1, 1, 6);
    settle();
    check("hazard_stall", int'(stall), 2);
    inst_val = 1'b0;
    settle();
    check("hazard_no_inst_stall", int'(stall), 0);
    inst_val = 1'b1;
    iss_val = '0;
    settle();
    check("no_hazard_stall", int'(stall), 0);
    iss_dst_en = '0;

    // Two slots writing the same register: youngest wins.
    clear_srcs();
    drive_issue(0, 7, 0, 0, 1);
    drive_issue(1, 7, 1, 0, 11);
    tick();
    drive_src(0, 0, 7);
    settle();
    check("youngest_tag", get_tag(0, 0), 11);
    check("youngest_pipe", get_pipe(0, 0), 1);
    check("youngest_stage", get_stage(0, 0), 3);

    // Register 0 is never pending.
    drive_issue(0, 0, 0, 0, 6);
    tick();
    drive_src(0, 1, 0);
    settle();
    check("r0_sel", get_sel(0, 1), 0);

    // Flush with four pending registers and a simultaneous issue.
    clear_srcs();
    drive_issue(0, 11, 0, 0, 12);
    drive_issue(1, 12, 0, 0, 13);
    tick();
    drive_issue(0, 13, 0, 0, 14);
    drive_issue(1, 14, 0, 0, 15);
    tick();
    drive_src(0, 0, 11); drive_src(0, 1, 12);
    drive_src(1, 0, 13); drive_src(1, 1, 14);
    settle();
    check("preflush_sel_r11", get_sel(0, 0), 1);
    check("preflush_stage_r11", get_stage(0, 0), 1);
    check("preflush_sel_r14", get_sel(1, 1), 1);
    flush = 1'b1;
    drive_issue(0, 8, 0, 0, 16);
    tick();
    check("flush_sel_r11", get_sel(0, 0), 0);
    check("flush_sel_r12", get_sel(0, 1), 0);
    check("flush_sel_r13", get_sel(1, 0), 0);
    check("flush_sel_r14", get_sel(1, 1), 0);
    clear_srcs();
    drive_src(0, 0, 8);
    drive_src(1, 0, 7);
    settle();
    check("flush_drop_r8", get_sel(0, 0), 0);
    check("flush_sel_r7", get_sel(1, 0), 0);
    check("flush_stall", int'(stall), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_param_scoreboard.md
# riscv_param_scoreboard

N-wide, parameterised register scoreboard for the IO2I out-of-order-issue core family. It tracks every architectural register with an in-flight writer: pipe, stage position, result class and ROB tag. For each issue slot it produces per-operand bypass selects and stall requests. Pending state is retired from ROB commit tags (tag-checked, so a newer writer is never cleared by an older commit), and the whole board is cleared on pipeline flush. It sits between the issue stage and the X0 operand muxes, replacing the fixed 2-wide scoreboard.

## Interface
- NREG, 32: architectural registers; register index width RW = clog2(NREG).
- ISSUE_W, 2: issue slots per cycle; slot 0 is oldest.
- NPIPE, 2: execution pipes; pipe id width PW = max(1, clog2(NPIPE)).
- DEPTH, 5: stages in a long pipe (X0..X(DEPTH-2), W); stage index width SW = clog2(DEPTH).
- SHORT_POS, 1: one-hot insertion bit for short pipes (1 = X3-equivalent, i.e. one stage before W).
- LONG_MASK, 'b01: bit p set means pipe p is long (inserts at bit DEPTH-1); clear means short.
- MUL_READY, 1: highest latency bit at which a MULDIV result is bypassable.
- TAG_W, 5: ROB tag width.
- NCOMMIT, 2: ROB commit ports.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- iss_val  in  ISSUE_W  slot k issues this cycle
- iss_dst, iss_src0, iss_src1  in  ISSUE_W*RW  register indices, slot-major
- iss_dst_en, iss_src0_en, iss_src1_en  in  ISSUE_W  enables
- iss_pipe  in  ISSUE_W*PW  destination pipe per slot
- iss_func  in  ISSUE_W*2  00 ALU, 01 MEM, 10 MULDIV, 11 reserved (treated as ALU)
- iss_tag  in  ISSUE_W*TAG_W  ROB tag of slot k
- inst_val  in  1  slots hold valid instructions (gates stalls)
- stall_stage  in  NPIPE*DEPTH  per-pipe per-stage stall, bit 0 = W
- commit_val  in  NCOMMIT  commit port valid
- commit_tag  in  NCOMMIT*TAG_W  committed ROB tag
- flush  in  1  clear all tracking
- byp_sel  out  ISSUE_W*2*2  per operand (slot k, op j at [(2k+j)*2 +: 2]): 0 regfile, 1 pipe stage, 2 ROB
- byp_pipe  out  ISSUE_W*2*PW  source pipe when byp_sel = 1
- byp_stage  out  ISSUE_W*2*SW  stage when byp_sel = 1 (0 = X0 … DEPTH-1 = W)
- byp_tag  out  ISSUE_W*2*TAG_W  producer ROB tag, valid when byp_sel != 0
- stall  out  ISSUE_W  slot k must not issue

## Operation
Per-register state: pending, pipe, lat[DEPTH-1:0] (one-hot or zero), func, tag.

- **Issue.** For each k with iss_val[k] and iss_dst_en[k], the entry iss_dst[k] gets:
  - pending = 1;
  - pipe, func and tag from the slot;
  - lat = 1<<(DEPTH-1) if the pipe is long, otherwise 1<<SHORT_POS.
  - If several slots write the same dst, the highest k (youngest) wins.
- **Shift.** Every non-issued entry with lat != 0 and pipe p:
  - if the stage at the set bit is stalled (stall_stage[p*DEPTH + bit]), lat holds;
  - otherwise lat shifts right by 1. W (bit 0) shifts to 0, meaning the value now resides in the ROB.
- **Commit.** A pending entry clears when some commit_val[c] is set and commit_tag[c] equals its tag. Issue to the same register in the same cycle takes priority over the clear.
- **Flush.** Clears pending and lat for all entries next cycle. Flush has priority over issue and commit.
- **Bypass.** An operand is *live* when src_en is set, the source is pending, and the source index is not 0.
  - live and lat != 0: byp_sel = 1; byp_stage = DEPTH-1-position(lat); byp_pipe = entry pipe.
  - live and lat == 0: byp_sel = 2.
  - not live: byp_sel = 0.
  - byp_tag is always the entry tag. byp_pipe and byp_stage are 0 when byp_sel != 1.
- **Readiness by func.**
  - ALU: always ready.
  - MEM: ready when lat < 1<<(DEPTH-1).
  - MULDIV: ready when lat < 1<<(MUL_READY+1).
  - Any func: ready when lat == 0.
- **Stall.** stall[k] = inst_val & (any live operand not ready | intra-bundle hazard | stall[k-1]).
  - Intra-bundle hazard: a live-enabled source of slot k equals iss_dst of some j < k with iss_dst_en[j] and iss_val[j].
  - stall[k-1] term gives in-order issue within the bundle.
- Register 0 is never marked pending.

## Timing
- Outputs are combinational from current state and current slot inputs. They reflect state before this cycle's issue, commit and flush.
- State updates at posedge clk. A destination issued in cycle t is visible to bypass in cycle t+1 at stage X0 (long) or SHORT_POS (short).
- Reset: all state zero; byp_sel/byp_pipe/byp_stage/byp_tag = 0, stall = 0. Reset mid-operation discards everything in one cycle.
- Long-pipe unstalled lifetime: DEPTH cycles in stages, then ROB until commit.

## Test plan
- **Reset.** Assert reset 2 cycles with state loaded → all outputs 0; a src on any reg gives byp_sel 0.
- **Long ALU walk.** Issue r5 on pipe 0 (long), ALU, tag 7. Next cycles src0 = r5 → byp_sel 1 with stage 0,1,2,3,4, then byp_sel 2 with tag 7. Commit tag 7 → byp_sel 0.
- **Stalls.**
  - MULDIV r3 on a long pipe: stall=1 while at stage X0/X1/X2; released at X3 (stage 3).
  - MEM on a long pipe: stall only while at X0.
  - stall_stage on X1 holds the stage at 1 across 3 cycles.
- **Stale commit.** Issue r4 with tag 2, then r4 with tag 9. Commit tag 2 → r4 stays pending; commit tag 9 → r4 cleared.
- **Intra-bundle hazard.**
  - slot0 dst r6, slot1 src1 r6 → stall = 'b10.
  - slot0 stalled for any reason → slot1 stalled.
- **Flush.** Flush with 4 pending regs → next cycle all byp_sel 0. Simultaneous issue to r8 in the flush cycle is dropped.
